// File: rtl/player_ctrl.sv
// player_ctrl: play/pause/skip FSM with song index, repeat mode and beat generator
module player_ctrl #(
    parameter int NUM_SONGS  = 4,
    parameter int SONG_W     = 2,
    parameter int BEAT_COUNT = 1000,
    parameter int FF_RATE    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_button,
    input  logic              next_button,
    input  logic              prev_button,
    input  logic              fast_forward_button,
    input  logic              repeat_button,
    input  logic              song_done,
    output logic              play,
    output logic [SONG_W-1:0] song,
    output logic              reset_player,
    output logic              beat,
    output logic              ff_active,
    output logic              repeat_mode
);
    localparam int CW = $clog2(BEAT_COUNT);
    typedef enum logic [1:0] {PAUSED, PLAYING, ADVANCE} state_t;
    state_t            r_state, r_target, w_next, w_target;
    logic [SONG_W-1:0] r_song, w_song;
    logic [CW-1:0]     r_count;
    logic [CW:0]       w_inc, w_sum;
    logic              w_wrap, w_next_btn, w_prev_btn, w_last, w_ff;
    logic              r_play, r_reset_player, r_beat, r_ff, r_repeat;

    assign w_last     = r_song == SONG_W'(NUM_SONGS - 1);
    assign w_next_btn = next_button & ~prev_button;
    assign w_prev_btn = prev_button & ~next_button;
    assign w_ff       = fast_forward_button && r_state == PLAYING;
    assign w_inc      = w_ff ? (CW+1)'(FF_RATE) : (CW+1)'(1);
    assign w_sum      = {1'b0, r_count} + w_inc;
    assign w_wrap     = w_sum >= (CW+1)'(BEAT_COUNT);

    // next state, post-advance target and next song index, by priority skip > song_done > play
    always_comb begin
        w_next   = r_state;
        w_target = r_target;
        w_song   = r_song;
        if (r_state == ADVANCE) begin
            w_next = r_target;
        end else if (w_next_btn) begin
            w_next   = ADVANCE;
            w_target = PAUSED;
            w_song   = w_last ? '0 : r_song + 1'b1;
        end else if (w_prev_btn) begin
            w_next   = ADVANCE;
            w_target = PAUSED;
            w_song   = (r_song == '0) ? SONG_W'(NUM_SONGS - 1) : r_song - 1'b1;
        end else if (song_done && r_state == PLAYING) begin
            w_next   = ADVANCE;
            w_target = (r_repeat || !w_last) ? PLAYING : PAUSED;
            w_song   = r_repeat ? r_song : (w_last ? '0 : r_song + 1'b1);
        end else if (play_button) begin
            w_next = (r_state == PLAYING) ? PAUSED : PLAYING;
        end
    end

    // FSM registers and registered play/restart outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= PAUSED;
            r_target       <= PAUSED;
            r_song         <= '0;
            r_play         <= 1'b0;
            r_reset_player <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_target       <= w_target;
            r_song         <= w_song;
            r_play         <= w_next == PLAYING;
            r_reset_player <= w_next == ADVANCE;
        end
    end

    // beat counter: cleared on entering ADVANCE, advances while playing, holds otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_beat  <= 1'b0;
        end else if (w_next == ADVANCE) begin
            r_count <= '0;
            r_beat  <= 1'b0;
        end else if (r_state == PLAYING) begin
            r_count <= w_wrap ? '0 : w_sum[CW-1:0];
            r_beat  <= w_wrap;
        end else begin
            r_beat  <= 1'b0;
        end
    end

    // fast-forward indicator and repeat toggle, independent of FSM priority
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ff     <= 1'b0;
            r_repeat <= 1'b0;
        end else begin
            r_ff     <= w_ff;
            r_repeat <= r_repeat ^ repeat_button;
        end
    end

    assign play         = r_play;
    assign song         = r_song;
    assign reset_player = r_reset_player;
    assign beat         = r_beat;
    assign ff_active    = r_ff;
    assign repeat_mode  = r_repeat;
endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl: directed scoreboard bench for player_ctrl (4 songs, 10-clock beat, ff rate 3)
module tb_player_ctrl;
    typedef logic [6:0] exp_t;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       play_button = 1'b0, next_button = 1'b0, prev_button = 1'b0;
    logic       fast_forward_button = 1'b0, repeat_button = 1'b0, song_done = 1'b0;
    logic       play, reset_player, beat, ff_active, repeat_mode;
    logic [1:0] song;
    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;

    player_ctrl #(.NUM_SONGS(4), .SONG_W(2), .BEAT_COUNT(10), .FF_RATE(3)) dut (
        .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
        .prev_button(prev_button), .fast_forward_button(fast_forward_button),
        .repeat_button(repeat_button), .song_done(song_done), .play(play), .song(song),
        .reset_player(reset_player), .beat(beat), .ff_active(ff_active), .repeat_mode(repeat_mode)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic p, input logic [1:0] s, input logic rp,
                                input logic b, input logic f, input logic r);
        return {p, s, rp, b, f, r};
    endfunction

    task automatic step(input string tag, input exp_t ex);
        exp_t obs, want;
        q.push_back(ex);
        @(posedge clk);
        #1;
        {play_button, next_button, prev_button, repeat_button, song_done} = '0;
        obs  = {play, song, reset_player, beat, ff_active, repeat_mode};
        want = q.pop_front();
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed={play,song,rp,beat,ff,rep}=%b expected=%b", tag, obs, want);
        end
    endtask

    initial begin
        reset = 1'b1; play_button = 1'b1; next_button = 1'b1;
        step("reset", mk(0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        play_button = 1'b1; step("play_on", mk(1, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 24; i++) step("beat_period10", mk(1, 0, 0, i % 10 == 0, 0, 0));
        play_button = 1'b1; step("pause", mk(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) step("paused_no_beat", mk(0, 0, 0, 0, 0, 0));
        play_button = 1'b1; step("resume", mk(1, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 5; i++) step("count_held", mk(1, 0, 0, i == 5, 0, 0));
        fast_forward_button = 1'b1;
        for (int i = 1; i <= 8; i++) step("ff_period4", mk(1, 0, 0, i % 4 == 0, 1, 0));
        fast_forward_button = 1'b0;
        for (int i = 1; i <= 10; i++) step("ff_release", mk(1, 0, 0, i == 10, 0, 0));
        play_button = 1'b1; step("pause2", mk(0, 0, 0, 0, 0, 0));
        next_button = 1'b1; step("next_adv", mk(0, 1, 1, 0, 0, 0));
        step("next_paused", mk(0, 1, 0, 0, 0, 0));
        play_button = 1'b1; step("play_s1", mk(1, 1, 0, 0, 0, 0));
        song_done = 1'b1; step("done_adv_s2", mk(0, 2, 1, 0, 0, 0));
        step("done_play_s2", mk(1, 2, 0, 0, 0, 0));
        song_done = 1'b1; step("done_adv_s3", mk(0, 3, 1, 0, 0, 0));
        step("done_play_s3", mk(1, 3, 0, 0, 0, 0));
        song_done = 1'b1; step("done_last_adv", mk(0, 0, 1, 0, 0, 0));
        step("done_last_paused", mk(0, 0, 0, 0, 0, 0));
        song_done = 1'b1; step("done_ignored_paused", mk(0, 0, 0, 0, 0, 0));
        repeat_button = 1'b1; step("repeat_on", mk(0, 0, 0, 0, 0, 1));
        play_button = 1'b1; step("play_rep", mk(1, 0, 0, 0, 0, 1));
        song_done = 1'b1; step("repeat_adv", mk(0, 0, 1, 0, 0, 1));
        repeat_button = 1'b1; play_button = 1'b1; next_button = 1'b1;
        step("adv_ignores_btns", mk(1, 0, 0, 0, 0, 0));
        play_button = 1'b1; step("pause3", mk(0, 0, 0, 0, 0, 0));
        prev_button = 1'b1; step("prev_wrap_adv", mk(0, 3, 1, 0, 0, 0));
        step("prev_wrap_paused", mk(0, 3, 0, 0, 0, 0));
        next_button = 1'b1; step("next_wrap_adv", mk(0, 0, 1, 0, 0, 0));
        step("next_wrap_paused", mk(0, 0, 0, 0, 0, 0));
        next_button = 1'b1; prev_button = 1'b1; step("next_prev_ignored", mk(0, 0, 0, 0, 0, 0));
        next_button = 1'b1; play_button = 1'b1; step("next_over_play", mk(0, 1, 1, 0, 0, 0));
        step("next_over_play_paused", mk(0, 1, 0, 0, 0, 0));
        play_button = 1'b1; step("play_s1b", mk(1, 1, 0, 0, 0, 0));
        next_button = 1'b1; step("next_from_play", mk(0, 2, 1, 0, 0, 0));
        step("next_from_play_paused", mk(0, 2, 0, 0, 0, 0));
        repeat_button = 1'b1; step("repeat_on2", mk(0, 2, 0, 0, 0, 1));
        next_button = 1'b1; step("adv_before_reset", mk(0, 3, 1, 0, 0, 1));
        reset = 1'b1; play_button = 1'b1; step("reset_in_adv", mk(0, 0, 0, 0, 0, 0));
        reset = 1'b0; step("no_residual_adv", mk(0, 0, 0, 0, 0, 0));
        play_button = 1'b1; step("play_after_reset", mk(1, 0, 0, 0, 0, 0));
        fast_forward_button = 1'b1;
        for (int i = 0; i < 2; i++) step("ff_mid_beat", mk(1, 0, 0, 0, 1, 0));
        reset = 1'b1; step("reset_mid_beat", mk(0, 0, 0, 0, 0, 0));
        reset = 1'b0; fast_forward_button = 1'b0;
        step("no_residual_beat", mk(0, 0, 0, 0, 0, 0));
        play_button = 1'b1; step("play_fresh", mk(1, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 10; i++) step("count_cleared", mk(1, 0, 0, i == 10, 0, 0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
